// File: rtl/sync_word_pkg.sv
// sync_word_pkg: shared FSM state type, sizing helper and error-flag
// bit positions for the sync word loader.
package sync_word_pkg;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        DRAIN   = 2'd1,
        PENDING = 2'd2
    } state_t;

    localparam int ERR_SHORT = 0;
    localparam int ERR_LONG  = 1;

    function automatic int beats_for(input int carriers, input int width);
        return (carriers + width - 1) / width;
    endfunction

endpackage

// File: rtl/sync_word_loader.sv
// sync_word_loader: double-buffered sync word loader. A config packet fills
// a shadow register; a good packet commits it to sync_word atomically.
// Ports:
//   s_axis_config_aclk/aresetn  clock, async active-low reset
//   s_axis_config_t*            AXI-Stream config slave (tstrb ignored)
//   frame_boundary              commit strobe from the framer
//   sync_word, sync_word_valid  active word and "ever committed" flag
//   commit, load_error          single-cycle event pulses
//   err_status                  sticky {long, short} packet error flags
module sync_word_loader
    import sync_word_pkg::*;
#(
    parameter int USED_CARRIERS      = 800,
    parameter int S_AXIS_TDATA_WIDTH = 32,
    parameter bit COMMIT_ON_BOUNDARY = 1'b1
) (
    input  logic                            s_axis_config_aclk,
    input  logic                            s_axis_config_aresetn,
    output logic                            s_axis_config_tready,
    input  logic [S_AXIS_TDATA_WIDTH-1:0]   s_axis_config_tdata,
    input  logic [S_AXIS_TDATA_WIDTH/8-1:0] s_axis_config_tstrb,
    input  logic                            s_axis_config_tlast,
    input  logic                            s_axis_config_tvalid,
    input  logic                            frame_boundary,
    output logic [USED_CARRIERS-1:0]        sync_word,
    output logic                            sync_word_valid,
    output logic                            commit,
    output logic                            load_error,
    output logic [1:0]                      err_status
);

    localparam int W     = S_AXIS_TDATA_WIDTH;
    localparam int BEATS = beats_for(USED_CARRIERS, W);
    localparam int CW    = $clog2(BEATS + 1);
    localparam int SW    = BEATS * W;
    localparam int OW    = (SW > 1) ? $clog2(SW) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    state_t          state, state_n;
    logic [CW-1:0]   beat_cnt, cnt_n;
    logic [SW-1:0]   shadow, shadow_n;
    logic [OW-1:0]   ofs;
    logic [1:0]      err_n;
    logic            commit_n;
    logic            error_n;
    logic            load_word;
    logic            accept;
    logic            unused_tstrb;

    assign unused_tstrb         = ^s_axis_config_tstrb;
    assign s_axis_config_tready = (state != PENDING);
    assign accept = s_axis_config_tvalid && s_axis_config_tready;
    assign ofs    = OW'(beat_cnt) * OW'(W);

    always_comb begin
        state_n   = state;
        cnt_n     = beat_cnt;
        shadow_n  = shadow;
        err_n     = err_status;
        commit_n  = 1'b0;
        error_n   = 1'b0;
        load_word = 1'b0;
        unique case (state)
            FILL: begin
                if (accept) begin
                    shadow_n[ofs +: W] = s_axis_config_tdata;
                    if (s_axis_config_tlast && beat_cnt == LAST) begin
                        err_n   = 2'b00;
                        cnt_n   = '0;
                        state_n = PENDING;
                        // Without boundary gating the word goes out at the
                        // same edge that stores the final beat.
                        if (!COMMIT_ON_BOUNDARY) begin
                            load_word = 1'b1;
                            commit_n  = 1'b1;
                        end
                    end else if (s_axis_config_tlast) begin
                        error_n          = 1'b1;
                        err_n[ERR_SHORT] = 1'b1;
                        cnt_n            = '0;
                    end else if (beat_cnt == LAST) begin
                        error_n         = 1'b1;
                        err_n[ERR_LONG] = 1'b1;
                        cnt_n           = '0;
                        state_n         = DRAIN;
                    end else begin
                        cnt_n = beat_cnt + CW'(1);
                    end
                end
            end
            DRAIN: begin
                if (accept && s_axis_config_tlast) begin
                    cnt_n   = '0;
                    state_n = FILL;
                end
            end
            PENDING: begin
                if (!COMMIT_ON_BOUNDARY) begin
                    state_n = FILL;
                end else if (frame_boundary) begin
                    load_word = 1'b1;
                    commit_n  = 1'b1;
                    state_n   = FILL;
                end
            end
            default: state_n = FILL;
        endcase
    end

    always_ff @(posedge s_axis_config_aclk or negedge s_axis_config_aresetn) begin
        if (!s_axis_config_aresetn) begin
            state           <= FILL;
            beat_cnt        <= '0;
            shadow          <= '0;
            sync_word       <= '0;
            sync_word_valid <= 1'b0;
            commit          <= 1'b0;
            load_error      <= 1'b0;
            err_status      <= 2'b00;
        end else begin
            state      <= state_n;
            beat_cnt   <= cnt_n;
            shadow     <= shadow_n;
            commit     <= commit_n;
            load_error <= error_n;
            err_status <= err_n;
            if (load_word) begin
                // Slicing drops the padding bits of the final beat.
                sync_word       <= shadow_n[USED_CARRIERS-1:0];
                sync_word_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sync_word_loader.sv
// tb_sync_word_loader: three loader instances (W=32 boundary, W=64 boundary,
// W=32 immediate) checked every cycle against a packet-level model.
module tb_sync_word_loader;

    localparam int UC = 800;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic [63:0]    tdata  [3];
    logic           tvalid [3];
    logic           tlast  [3];
    logic           fb     [3];
    logic           tready [3];
    logic           cmt    [3];
    logic           lerr   [3];
    logic           swv    [3];
    logic [1:0]     err    [3];
    logic [UC-1:0]  sw     [3];

    int checks   = 0;
    int failures = 0;

    sync_word_loader #(
        .USED_CARRIERS(UC), .S_AXIS_TDATA_WIDTH(32), .COMMIT_ON_BOUNDARY(1'b1)
    ) u0 (
        .s_axis_config_aclk(clk), .s_axis_config_aresetn(rst_n),
        .s_axis_config_tready(tready[0]), .s_axis_config_tdata(tdata[0][31:0]),
        .s_axis_config_tstrb(4'hF), .s_axis_config_tlast(tlast[0]),
        .s_axis_config_tvalid(tvalid[0]), .frame_boundary(fb[0]),
        .sync_word(sw[0]), .sync_word_valid(swv[0]), .commit(cmt[0]),
        .load_error(lerr[0]), .err_status(err[0])
    );

    sync_word_loader #(
        .USED_CARRIERS(UC), .S_AXIS_TDATA_WIDTH(64), .COMMIT_ON_BOUNDARY(1'b1)
    ) u1 (
        .s_axis_config_aclk(clk), .s_axis_config_aresetn(rst_n),
        .s_axis_config_tready(tready[1]), .s_axis_config_tdata(tdata[1]),
        .s_axis_config_tstrb(8'hFF), .s_axis_config_tlast(tlast[1]),
        .s_axis_config_tvalid(tvalid[1]), .frame_boundary(fb[1]),
        .sync_word(sw[1]), .sync_word_valid(swv[1]), .commit(cmt[1]),
        .load_error(lerr[1]), .err_status(err[1])
    );

    sync_word_loader #(
        .USED_CARRIERS(UC), .S_AXIS_TDATA_WIDTH(32), .COMMIT_ON_BOUNDARY(1'b0)
    ) u2 (
        .s_axis_config_aclk(clk), .s_axis_config_aresetn(rst_n),
        .s_axis_config_tready(tready[2]), .s_axis_config_tdata(tdata[2][31:0]),
        .s_axis_config_tstrb(4'hF), .s_axis_config_tlast(tlast[2]),
        .s_axis_config_tvalid(tvalid[2]), .frame_boundary(fb[2]),
        .sync_word(sw[2]), .sync_word_valid(swv[2]), .commit(cmt[2]),
        .load_error(lerr[2]), .err_status(err[2])
    );

    function automatic int w_of(int i);
        return (i == 1) ? 64 : 32;
    endfunction

    function automatic int beats_of(int i);
        return (UC + w_of(i) - 1) / w_of(i);
    endfunction

    function automatic bit cob_of(int i);
        return i != 2;
    endfunction

    // Model: 0 collecting, 1 discarding, 2 waiting to commit.
    int             m_mode [3];
    int             m_n    [3];
    logic [63:0]    got    [3][32];
    logic [UC-1:0]  m_sw   [3];
    logic [UC-1:0]  m_pend [3];
    logic           m_v    [3];
    logic           m_c    [3];
    logic           m_e    [3];
    logic [1:0]     m_err  [3];
    logic [63:0]    md;

    function automatic logic [UC-1:0] assemble(int i);
        logic [831:0] acc;
        acc = '0;
        for (int k = 0; k < beats_of(i); k++)
            acc = acc | ({768'b0, got[i][k]} << (k * w_of(i)));
        return acc[UC-1:0];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                m_mode[i] = 0; m_n[i] = 0; m_sw[i] = '0; m_pend[i] = '0;
                m_v[i] = 1'b0; m_c[i] = 1'b0; m_e[i] = 1'b0; m_err[i] = 2'b00;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                md = (w_of(i) == 64) ? tdata[i] : {32'b0, tdata[i][31:0]};
                m_c[i] = 1'b0;
                m_e[i] = 1'b0;
                if (m_mode[i] == 2) begin
                    if (!cob_of(i)) begin
                        m_mode[i] = 0;
                    end else if (fb[i]) begin
                        m_sw[i] = m_pend[i]; m_v[i] = 1'b1;
                        m_c[i] = 1'b1; m_mode[i] = 0;
                    end
                end else if (tvalid[i]) begin
                    if (m_mode[i] == 1) begin
                        if (tlast[i]) m_mode[i] = 0;
                    end else begin
                        got[i][m_n[i]] = md;
                        m_n[i]++;
                        if (tlast[i] && m_n[i] == beats_of(i)) begin
                            m_err[i] = 2'b00; m_n[i] = 0; m_mode[i] = 2;
                            m_pend[i] = assemble(i);
                            if (!cob_of(i)) begin
                                m_sw[i] = m_pend[i]; m_v[i] = 1'b1; m_c[i] = 1'b1;
                            end
                        end else if (tlast[i]) begin
                            m_e[i] = 1'b1; m_err[i] = m_err[i] | 2'b01; m_n[i] = 0;
                        end else if (m_n[i] == beats_of(i)) begin
                            m_e[i] = 1'b1; m_err[i] = m_err[i] | 2'b10;
                            m_n[i] = 0; m_mode[i] = 1;
                        end
                    end
                end
            end
        end
    end

    task automatic chk(string nm, logic [UC-1:0] act, logic [UC-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst_n)
                chk($sformatf("tready%0d", i), UC'(tready[i]), UC'(m_mode[i] != 2));
            chk($sformatf("sync_word%0d", i), sw[i], m_sw[i]);
            chk($sformatf("valid%0d", i), UC'(swv[i]), UC'(m_v[i]));
            chk($sformatf("commit%0d", i), UC'(cmt[i]), UC'(m_c[i]));
            chk($sformatf("load_error%0d", i), UC'(lerr[i]), UC'(m_e[i]));
            chk($sformatf("err_status%0d", i), UC'(err[i]), UC'(m_err[i]));
        end
    end

    int n_commit [3] = '{0, 0, 0};
    int n_lerr   [3] = '{0, 0, 0};
    int n_low    [3] = '{0, 0, 0};

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (cmt[i]) n_commit[i]++;
            if (lerr[i]) n_lerr[i]++;
            if (rst_n && !tready[i]) n_low[i]++;
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_beat(int i, logic [63:0] d, logic l);
        bit ok;
        int t;
        tdata[i] = d; tlast[i] = l; tvalid[i] = 1'b1;
        ok = 1'b0; t = 0;
        while (!ok && t < 100) begin
            @(negedge clk);
            ok = tready[i];
            @(posedge clk);
            #1;
            t++;
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL handshake%0d timeout got=%0d want=accept", i, t);
        end
    endtask

    task automatic send_pkt(int i, int n, logic [63:0] base, bit last);
        for (int k = 0; k < n; k++)
            send_beat(i, base + 64'(k), last && (k == n - 1));
    endtask

    task automatic pulse_fb(int i);
        fb[i] = 1'b1;
        tick(1);
        fb[i] = 1'b0;
    endtask

    int s_low, s_err, s_cmt;

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tdata[i] = '0; tvalid[i] = 1'b0; tlast[i] = 1'b0; fb[i] = 1'b0;
        end
        tick(3);
        rst_n = 1'b1;
        tick(1);
        chk("rst_tready", UC'(tready[0]), UC'(1));
        chk("rst_word", sw[0], '0);
        chk("rst_err", UC'(err[0]), UC'(0));

        // 25 beats of beat index, boundary after 10 idle pending cycles.
        s_low = n_low[0];
        send_pkt(0, 25, 64'd0, 1'b1);
        tvalid[0] = 1'b0;
        tick(10);
        chk("t1_no_early_commit", UC'(cmt[0]), UC'(0));
        pulse_fb(0);
        chk("t1_commit", UC'(cmt[0]), UC'(1));
        chk("t1_lo", UC'(sw[0][31:0]), UC'(32'd0));
        chk("t1_mid", UC'(sw[0][351:320]), UC'(32'd10));
        chk("t1_hi", UC'(sw[0][799:768]), UC'(32'd24));
        tick(2);
        chk("t1_tready_low", UC'(n_low[0] - s_low), UC'(11));

        // W=64: 13 beats, upper half of the final beat dropped.
        s_err = n_lerr[1];
        for (int k = 0; k < 12; k++)
            send_beat(1, {32'h5555_0000 + 32'(k), 32'(k)}, 1'b0);
        send_beat(1, 64'hFFFF_FFFF_AAAA_AAAA, 1'b1);
        tvalid[1] = 1'b0;
        tick(2);
        pulse_fb(1);
        chk("t2_hi", UC'(sw[1][799:768]), UC'(32'hAAAA_AAAA));
        chk("t2_lo", UC'(sw[1][63:0]), UC'(64'h5555_0000_0000_0000));
        chk("t2_no_err", UC'(n_lerr[1] - s_err), UC'(0));

        // Short packet, then a good one clears the flag.
        s_err = n_lerr[0];
        send_pkt(0, 10, 64'hDEAD_0000, 1'b1);
        tvalid[0] = 1'b0;
        chk("t3_pulse", UC'(lerr[0]), UC'(1));
        tick(1);
        chk("t3_err", UC'(err[0]), UC'(2'b01));
        chk("t3_word_kept", UC'(sw[0][799:768]), UC'(32'd24));
        chk("t3_one_pulse", UC'(n_lerr[0] - s_err), UC'(1));
        send_pkt(0, 25, 64'h1000, 1'b1);
        tvalid[0] = 1'b0;
        chk("t3_err_clr", UC'(err[0]), UC'(0));
        tick(1);
        pulse_fb(0);
        chk("t3_new_lo", UC'(sw[0][31:0]), UC'(32'h1000));
        chk("t3_new_hi", UC'(sw[0][799:768]), UC'(32'h1018));

        // Long packet: 30 beats, all accepted, tail discarded.
        s_err = n_lerr[0];
        s_low = n_low[0];
        send_pkt(0, 30, 64'h2000, 1'b1);
        tvalid[0] = 1'b0;
        tick(1);
        chk("t4_err", UC'(err[0]), UC'(2'b10));
        chk("t4_one_pulse", UC'(n_lerr[0] - s_err), UC'(1));
        chk("t4_no_stall", UC'(n_low[0] - s_low), UC'(0));
        chk("t4_word_kept", UC'(sw[0][31:0]), UC'(32'h1000));
        send_pkt(0, 25, 64'h3000, 1'b1);
        tvalid[0] = 1'b0;
        tick(1);
        pulse_fb(0);
        chk("t4_next_hi", UC'(sw[0][799:768]), UC'(32'h3018));
        chk("t4_err_clr", UC'(err[0]), UC'(0));

        // Reset mid-packet.
        send_pkt(0, 12, 64'h4000, 1'b0);
        tvalid[0] = 1'b0;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk("t5_tready", UC'(tready[0]), UC'(1));
        chk("t5_word", sw[0], '0);
        chk("t5_valid", UC'(swv[0]), UC'(0));

        // Reset while pending: word lost, later boundary ignored.
        send_pkt(0, 25, 64'h5000, 1'b1);
        tvalid[0] = 1'b0;
        tick(3);
        s_cmt = n_commit[0];
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk("t5p_tready", UC'(tready[0]), UC'(1));
        pulse_fb(0);
        chk("t5p_no_commit", UC'(cmt[0]), UC'(0));
        tick(2);
        chk("t5p_word", sw[0], '0);
        chk("t5p_cnt", UC'(n_commit[0] - s_cmt), UC'(0));

        // Immediate commit, back-to-back packets, tvalid held high.
        s_low = n_low[2];
        s_cmt = n_commit[2];
        send_pkt(2, 25, 64'h6000, 1'b1);
        chk("t6_commit_a", UC'(cmt[2]), UC'(1));
        chk("t6_word_a", UC'(sw[2][799:768]), UC'(32'h6018));
        send_pkt(2, 25, 64'h7000, 1'b1);
        tvalid[2] = 1'b0;
        chk("t6_commit_b", UC'(cmt[2]), UC'(1));
        chk("t6_word_b", UC'(sw[2][31:0]), UC'(32'h7000));
        tick(3);
        chk("t6_low", UC'(n_low[2] - s_low), UC'(2));
        chk("t6_cnt", UC'(n_commit[2] - s_cmt), UC'(2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_word_loader.md
# sync_word_loader

Parametrised, double-buffered loader for the OFDM framer's sync (preamble) word. It accepts one sync word per AXI-Stream packet on the config port, holding it in a shadow register. It then commits the word atomically to the active output at a symbol boundary, so the framer never sees a partially written word. Malformed packets are detected and reported.

## Interface
Parameters:
- USED_CARRIERS, 800, width of the sync word in bits (one bit per used carrier).
- S_AXIS_TDATA_WIDTH, 32, config stream width; multiple of 8.
- COMMIT_ON_BOUNDARY, 1, behaviour of a complete load:
  - 1: commit waits for frame_boundary.
  - 0: commit happens on the cycle after the final beat.

Ports:
- s_axis_config_aclk  in  1  sole clock.
- s_axis_config_aresetn  in  1  reset; asynchronous, active-low.
- s_axis_config_tready  out  1  slave ready.
- s_axis_config_tdata  in  S_AXIS_TDATA_WIDTH  sync-word beat, LSB-first.
- s_axis_config_tstrb  in  S_AXIS_TDATA_WIDTH/8  ignored.
- s_axis_config_tlast  in  1  last beat of packet.
- s_axis_config_tvalid  in  1  beat valid.
- frame_boundary  in  1  single-cycle pulse from the framer at each frame start.
- sync_word  out  USED_CARRIERS  active sync word.
- sync_word_valid  out  1  high once at least one word has been committed.
- commit  out  1  one-cycle pulse when sync_word updates.
- load_error  out  1  one-cycle pulse on a malformed packet.
- err_status  out  2  sticky error flags, cleared by the next good load:
  - bit0: short packet.
  - bit1: long packet.

## Operation
- BEATS = ceil(USED_CARRIERS / S_AXIS_TDATA_WIDTH).
- beat_cnt width is $clog2(BEATS+1).
- Beat k writes shadow bits [k*W +: W]. On the final beat, bits above USED_CARRIERS-1 are dropped.
- States:
  - FILL (reset state): tready=1. Each accepted beat writes shadow and increments beat_cnt.
    - tlast with beat_cnt==BEATS-1: good load; go to PENDING, clear err_status.
    - tlast with beat_cnt<BEATS-1: short error; pulse load_error, set err_status[0], beat_cnt←0, stay in FILL.
    - No tlast on beat_cnt==BEATS-1: long error; pulse load_error, set err_status[1], go to DRAIN.
  - DRAIN: tready=1. Beats are discarded. Accepting tlast sets beat_cnt←0 and returns to FILL.
  - PENDING: tready=0.
    - COMMIT_ON_BOUNDARY=1: on frame_boundary, copy shadow to sync_word, set sync_word_valid, pulse commit, go to FILL.
    - COMMIT_ON_BOUNDARY=0: commit unconditionally on the first PENDING cycle.
- A frame_boundary in FILL or DRAIN has no effect.
- A frame_boundary on the same cycle as the good final beat is not used; the commit waits for the next boundary.
- sync_word changes only on commit. Errors never alter sync_word or sync_word_valid.
- Shadow contents from a failed packet are overwritten by the next packet; there is no need to clear them.

## Timing
- Reset values:
  - state=FILL, beat_cnt=0, shadow=0.
  - sync_word=0, sync_word_valid=0, commit=0, load_error=0, err_status=0.
  - tready=1 one cycle after reset deassertion. It is combinational from state, never from tvalid.
- Reset asserted mid-packet or in PENDING aborts the load. The uncommitted word is lost; sync_word returns to 0.
- Handshake: a beat transfers on tvalid&&tready. Upstream may hold tvalid while tready=0 (PENDING) without loss.
- Latency:
  - COMMIT_ON_BOUNDARY=0: final beat at cycle N gives commit and new sync_word at N+1, and tready high again at N+2.
  - COMMIT_ON_BOUNDARY=1: boundary sampled at cycle M gives sync_word updated at M+1, with commit high in the same cycle.
- load_error pulses in the cycle after the offending beat.
- All outputs are registered.

## Structure
- Package sync_word_pkg holds:
  - the state typedef (FILL, DRAIN, PENDING);
  - a function beats_for(carriers, width) used for BEATS and counter sizing;
  - the err_status bit-index constants.
- Single module; no sub-module is warranted. Shadow write is an indexed part-select; the final-beat truncation is handled by sizing shadow to BEATS*W and slicing.

## Test plan
- W=32, 800 carriers, 25-beat packet of beat index values, COMMIT_ON_BOUNDARY=1, boundary 10 cycles later -> sync_word[31:0]=0, sync_word[799:768]=24, commit one cycle after boundary, tready low for exactly those 10+1 cycles.
- W=64 -> 13 beats; final beat 0xFFFF_FFFF_AAAA_AAAA -> sync_word[799:768]=0xAAAA_AAAA, upper half dropped, no error.
- Short packet (tlast on beat 10 of 25) -> load_error pulse, err_status=01, sync_word unchanged; the following good packet commits and clears err_status.
- Long packet (30 beats, tlast on beat 29) -> load_error after beat 24, beats 25–29 accepted and discarded, err_status=10, next packet loads normally.
- Reset asserted at beat 12, and separately in PENDING -> all outputs 0, tready=1 one cycle after release, no commit.
- COMMIT_ON_BOUNDARY=0, back-to-back packets with continuous tvalid -> commit after each packet, with one tready-low cycle between packets.
